// File: rtl/s1_feature_fetcher.sv
// S1 feature fetcher: reads the window [win_start, win_end) from the feature buffer and streams it out.
// Define S1_FETCH_ERRCHK_EN to build the sticky window-length check that drives err.
module s1_feature_fetcher #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int FEATURE_NUM = 2048,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [ADDR_W-1:0] win_start,
  input  logic [ADDR_W-1:0] win_end,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic [ADDR_W-1:0] next_F,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FEATURE_NUM < 1) begin : g_bad_param
    $error("s1_feature_fetcher: FIFO_DEPTH must be a power of two >= 2 and FEATURE_NUM positive");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] next_f_q, next_f_d;
  logic              inflight_q, inflight_last_q;
  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, occupancy;
  logic [ADDR_W-1:0] win_len;
  logic              accept, credit_ok, issue, issue_last, push, pop;
  entry_t            head;

  assign win_len = win_end - win_start;
  assign accept  = win_valid && (state_q == S_IDLE);

  // Credit covers words already buffered plus the read whose data lands next cycle.
  assign occupancy  = count_q + CNT_W'(inflight_q);
  assign credit_ok  = occupancy < CNT_W'(FIFO_DEPTH);
  assign issue      = (state_q == S_FETCH) && credit_ok;
  assign issue_last = left_q == ADDR_W'(1);
  assign push       = inflight_q;
  assign head       = mem_q[rd_ptr_q];
  assign pop        = out_valid && out_ready;

  assign win_ready = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign rd_en     = issue;
  assign rd_addr   = cur_q;
  assign out_valid = count_q != '0;
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid && head.last;
  assign next_F    = next_f_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cur_d    = cur_q;
    end_d    = end_q;
    left_d   = left_q;
    next_f_d = next_f_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cur_d   = win_start;
          end_d   = win_end;
          left_d  = win_len;
          state_d = (win_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue) begin
          cur_d  = cur_q + ADDR_W'(1);
          left_d = left_q - ADDR_W'(1);
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head.last) state_d = S_DONE;
      end
      S_DONE: begin
        next_f_d = end_q;
        state_d  = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cur_q           <= '0;
      end_q           <= '0;
      left_q          <= '0;
      next_f_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      end_q           <= end_d;
      left_q          <= left_d;
      next_f_q        <= next_f_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{last: inflight_last_q, data: rd_data};
  end

`ifdef S1_FETCH_ERRCHK_EN
  localparam logic [ADDR_W-1:0] FEATURE_LEN = ADDR_W'(FEATURE_NUM);
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && (win_len != FEATURE_LEN)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/s1_feature_fetcher.md
# s1_feature_fetcher

Reads one feature window [start, end) from the feature buffer and streams it downstream with valid/ready backpressure. It is the consumer side of the S1 window calculation: it takes the (last_F, F1) pair as a window request and issues one buffer read per address. On completion it returns end as next_F, which feeds the following window's Fin. Addresses wrap modulo 2^ADDR_W.

## Interface
- ADDR_W, 12, feature address width; window bounds and addresses are modulo 2^ADDR_W
- DATA_W, 16, feature word width
- FEATURE_NUM, 2048, expected window length (64 SIMD x 32 lanes); used only by the error check
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- win_valid  in  1  window request valid
- win_ready  out  1  high only in IDLE
- win_start  in  ADDR_W  first address (last_F)
- win_end  in  ADDR_W  one past last address (F1)
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
- out_valid  out  1  feature word valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  feature word
- out_last  out  1  marks the final word of the window
- done  out  1  one-cycle pulse after the final word is accepted
- next_F  out  ADDR_W  win_end of the finished window; holds until the next done
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky length error; present only with S1_FETCH_ERRCHK_EN, otherwise tied 0

## Operation
- States and transitions:
  - IDLE -> FETCH on win_valid && win_ready. The bounds are latched and len = (win_end - win_start) mod 2^ADDR_W.
  - If len == 0: IDLE -> DONE directly. No reads are issued and no words are output.
  - FETCH: issue rd_en, rd_addr = cur, then cur = cur + 1 (wraps 4095 -> 0), and decrement the remaining-issue count. Issue only when fifo_count + inflight < FIFO_DEPTH.
  - FETCH -> DRAIN after the last read is issued.
  - DRAIN -> DONE when the word carrying out_last is accepted (out_valid && out_ready).
  - DONE -> IDLE after exactly one cycle. In DONE: done = 1 and next_F <= latched win_end.
- Read data is written into the FIFO in the cycle it returns. The credit rule makes FIFO overflow impossible.
- out_last = 1 only on the word read from address win_end - 1 (mod 2^ADDR_W).
- Output order equals address order; no words are dropped or duplicated.
- win_valid outside IDLE is ignored; the request is not latched.
- rst mid-window: the FSM returns to IDLE, FIFO and counters clear, in-flight rd_data is discarded, and no done pulse is generated.
- Reset values: win_ready = 1, rd_en = 0, rd_addr = 0, out_valid = 0, out_data = 0, out_last = 0, done = 0, next_F = 0, busy = 0, err = 0.

## Timing
- Request accepted at cycle T:
  - first rd_en at T+1
  - rd_data at T+2
  - first out_valid at T+3 (FIFO output registered)
- With out_ready held high: one word per cycle and no bubbles. A len-N window ends with out_last at T+N+2, done at T+N+3, and win_ready high again at T+N+4.
- out_valid low -> out_ready ignored. While out_valid && !out_ready, out_data and out_last hold stable.
- Backpressure stalls issue within one cycle of the FIFO plus in-flight count reaching FIFO_DEPTH.
- len == 0: done at T+1, win_ready at T+2.

## Configuration
- S1_FETCH_ERRCHK_EN defined:
  - At acceptance, err is set if len != FEATURE_NUM (mod 2^ADDR_W).
  - err stays set until rst. Fetch behaviour is unchanged.
- Not defined: no length comparator is built, and err is constant 0.

## Test plan
- Basic window: start = 0, end = 8, out_ready = 1, rd_data = address -> words 0..7. out_last on 7. done one cycle after; next_F = 8. Cycle counts match the Timing section.
- Wrap-around: start = 4092, end = 4 -> rd_addr sequence 4092, 4093, 4094, 4095, 0, 1, 2, 3. out_last on address 3; next_F = 4.
- Backpressure: start = 100, end = 116, out_ready toggling 1-0-0-1 pseudo-randomly -> all 16 words in order with no loss. Outstanding reads never exceed FIFO_DEPTH = 4; data stable while stalled.
- Chained windows: ini window 0..2048, then win_start = next_F, win_end = next_F + 2048 -> 4096 words total, addresses contiguous modulo 4096. Second window's next_F = 0.
- Empty and ignored requests:
  - start = end = 50 -> no rd_en, done at T+1, next_F = 50.
  - win_valid pulsed during FETCH -> ignored.
- Reset mid-window, plus error check:
  - rst asserted after 5 words of a 0..32 window -> all outputs at reset values the next cycle, no done pulse.
  - With S1_FETCH_ERRCHK_EN, window 0..8 -> err = 1 after acceptance. Without the macro, err = 0.
